// File: rtl/mul_pkg.sv
// Shared definitions for the sequential shift-add multiplier:
// FSM state encodings and the number of iterations per operation.
package mul_pkg;

   typedef enum logic [1:0] {
      MUL_IDLE = 2'd0,
      MUL_RUN  = 2'd1,
      MUL_DONE = 2'd2
   } mul_state_t;

   localparam int MUL_STEPS = 8;

endpackage : mul_pkg

// File: rtl/mul8_step.sv
// One combinational shift-add iteration. The addend carries the
// multiplicand in its upper half with a zero lower half, so adding it to
// the whole accumulator equals adding it to acc[2W:W] alone. The carry of
// that upper sum lands in the top accumulator bit before the right shift.
module mul8_step #(
   parameter int WIDTH = 8
) (
   input  logic [2*WIDTH:0]   acc,
   input  logic [2*WIDTH-1:0] addend,
   output logic [2*WIDTH:0]   next_acc
);

   logic [2*WIDTH:0] sum;

   // Conditionally add the aligned multiplicand, then shift right by one.
   always_comb begin
      sum      = acc + {1'b0, addend};
      next_acc = acc[0] ? (sum >> 1) : (acc >> 1);
   end

endmodule : mul8_step

// File: rtl/mul8_shift_add.sv
// Sequential unsigned multiplier: one multiplier bit per clock, start/busy
// request side and valid/ready result side. The FSM, iteration counter and
// all datapath registers live here; the arithmetic step is in mul8_step.
module mul8_shift_add
   import mul_pkg::*;
#(
   parameter int WIDTH = 8
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               start,
   input  logic [WIDTH-1:0]   a,
   input  logic [WIDTH-1:0]   b,
   output logic               busy,
   output logic               out_valid,
   input  logic               out_ready,
   output logic [2*WIDTH-1:0] product
);

   localparam int CNT_W = $clog2(WIDTH) + 1;
   localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

   mul_state_t         state;
   mul_state_t         next_state;
   logic               load;
   logic               step;
   logic [2*WIDTH:0]   acc;
   logic [2*WIDTH-1:0] addend;
   logic [2*WIDTH:0]   next_acc;
   logic [CNT_W-1:0]   cnt;

   mul8_step #(.WIDTH(WIDTH)) u_step (
      .acc      (acc),
      .addend   (addend),
      .next_acc (next_acc)
   );

   // State register; reset aborts any operation in flight.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= MUL_IDLE;
      else     state <= next_state;
   end

   // Next-state logic plus the load/step strobes for the datapath.
   always_comb begin
      next_state = state;
      load       = 1'b0;
      step       = 1'b0;
      case (state)
         MUL_IDLE: begin
            if (start) begin
               next_state = MUL_RUN;
               load       = 1'b1;
            end
         end
         MUL_RUN: begin
            step = 1'b1;
            if (cnt == LAST_CNT) next_state = MUL_DONE;
         end
         MUL_DONE: begin
            if (out_ready) begin
               if (start) begin
                  next_state = MUL_RUN;
                  load       = 1'b1;
               end else begin
                  next_state = MUL_IDLE;
               end
            end
         end
         default: next_state = MUL_IDLE;
      endcase
   end

   // Operand capture, iteration and result latch; product updates only on
   // the edge that enters DONE so it stays stable while out_valid is high.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         acc     <= '0;
         addend  <= '0;
         cnt     <= '0;
         product <= '0;
      end else if (load) begin
         addend <= {a, {WIDTH{1'b0}}};
         acc    <= {{(WIDTH+1){1'b0}}, b};
         cnt    <= '0;
      end else if (step) begin
         acc <= next_acc;
         cnt <= cnt + CNT_W'(1);
         if (cnt == LAST_CNT) product <= next_acc[2*WIDTH-1:0];
      end
   end

   // Status outputs decode directly from the state register.
   always_comb begin
      busy      = (state == MUL_RUN);
      out_valid = (state == MUL_DONE);
   end

endmodule : mul8_shift_add

// File: tb/tb_mul8_shift_add.sv
// Self-checking bench for mul8_shift_add against a plain a*b reference.
module tb_mul8_shift_add;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        start = 1'b0;
   logic [7:0]  a = '0;
   logic [7:0]  b = '0;
   logic        busy;
   logic        out_valid;
   logic        out_ready = 1'b0;
   logic [15:0] product;

   int checks = 0;
   int errors = 0;

   mul8_shift_add #(.WIDTH(8)) dut (
      .clk       (clk),
      .rst       (rst),
      .start     (start),
      .a         (a),
      .b         (b),
      .busy      (busy),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .product   (product)
   );

   always #5 clk = ~clk;

   function automatic logic [15:0] ref_mul(input logic [7:0] x, input logic [7:0] y);
      int p;
      p = int'(x) * int'(y);
      return p[15:0];
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Pulse start for one cycle, then wait for out_valid. lat counts edges
   // from the accept edge (inclusive) to the first cycle with out_valid.
   task automatic run_op(input logic [7:0] ra, input logic [7:0] rb,
                         output int busy_n, output int lat);
      a = ra;
      b = rb;
      start = 1'b1;
      tick();
      start = 1'b0;
      lat = 1;
      busy_n = 0;
      while (!out_valid && lat < 30) begin
         if (busy) busy_n++;
         tick();
         lat++;
      end
   endtask

   task automatic test_reset();
      int seen;
      rst = 1'b1;
      out_ready = 1'b0;
      tick();
      tick();
      checks++;
      if (product !== 16'h0) begin errors++; $display("FAIL reset_product got %h want 0000", product); end
      checks++;
      if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %b want 0", out_valid); end
      checks++;
      if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", busy); end
      rst = 1'b0;
      out_ready = 1'b1;
      seen = 0;
      for (int i = 0; i < 12; i++) begin
         tick();
         if (out_valid || busy) seen++;
      end
      checks++;
      if (seen !== 0) begin errors++; $display("FAIL idle_no_activity got %0d active cycles want 0", seen); end
   endtask

   task automatic test_basic();
      int bn, lat;
      out_ready = 1'b1;
      run_op(8'h0D, 8'h0B, bn, lat);
      checks++;
      if (bn !== 8) begin errors++; $display("FAIL basic_busy_cycles got %0d want 8", bn); end
      checks++;
      if (lat !== 9) begin errors++; $display("FAIL basic_latency got %0d want 9", lat); end
      checks++;
      if (product !== 16'h008F) begin errors++; $display("FAIL basic_product got %h want 008f", product); end
      tick();
      checks++;
      if (out_valid !== 1'b0) begin errors++; $display("FAIL basic_single_pulse got %b want 0", out_valid); end
   endtask

   task automatic test_corners();
      logic [7:0] ca [4] = '{8'hFF, 8'h00, 8'h80, 8'h01};
      logic [7:0] cb [4] = '{8'hFF, 8'hFF, 8'h02, 8'h01};
      logic [15:0] want;
      int bn, lat;
      out_ready = 1'b1;
      for (int i = 0; i < 4; i++) begin
         want = ref_mul(ca[i], cb[i]);
         run_op(ca[i], cb[i], bn, lat);
         checks++;
         if (product !== want) begin errors++; $display("FAIL corner_product %h*%h got %h want %h", ca[i], cb[i], product, want); end
         checks++;
         if (lat !== 9) begin errors++; $display("FAIL corner_latency %h*%h got %0d want 9", ca[i], cb[i], lat); end
         tick();
      end
   endtask

   task automatic test_random();
      logic [7:0] ra, rb;
      logic [15:0] want;
      int bn, lat, hold;
      for (int i = 0; i < 25; i++) begin
         ra = 8'($urandom);
         rb = 8'($urandom);
         want = ref_mul(ra, rb);
         hold = $urandom_range(0, 3);
         out_ready = (hold == 0);
         run_op(ra, rb, bn, lat);
         checks++;
         if (product !== want || lat !== 9) begin
            errors++;
            $display("FAIL random_op %h*%h got %h lat %0d want %h lat 9", ra, rb, product, lat, want);
         end
         for (int k = 0; k < hold; k++) begin
            tick();
            checks++;
            if (product !== want || out_valid !== 1'b1) begin
               errors++;
               $display("FAIL random_hold got %h valid %b want %h valid 1", product, out_valid, want);
            end
         end
         out_ready = 1'b1;
         tick();
      end
   endtask

   task automatic test_backpressure();
      int bn, lat, bad;
      out_ready = 1'b0;
      run_op(8'h5A, 8'h3C, bn, lat);
      bad = 0;
      for (int k = 0; k < 5; k++) begin
         if (k == 2) begin
            a = 8'h11;
            b = 8'h22;
            start = 1'b1;
         end else begin
            start = 1'b0;
         end
         if (product !== ref_mul(8'h5A, 8'h3C) || !out_valid || busy) bad++;
         tick();
      end
      start = 1'b0;
      checks++;
      if (bad !== 0 || product !== ref_mul(8'h5A, 8'h3C) || out_valid !== 1'b1) begin
         errors++;
         $display("FAIL backpressure_hold got %0d bad cycles product %h want 0 bad product %h", bad, product, ref_mul(8'h5A, 8'h3C));
      end
      out_ready = 1'b1;
      tick();
      checks++;
      if (out_valid !== 1'b0 || busy !== 1'b0) begin
         errors++;
         $display("FAIL backpressure_release got valid %b busy %b want 0 0", out_valid, busy);
      end
      tick();
      tick();
      checks++;
      if (out_valid !== 1'b0 || busy !== 1'b0) begin
         errors++;
         $display("FAIL backpressure_no_second got valid %b busy %b want 0 0", out_valid, busy);
      end
   endtask

   task automatic test_back_to_back();
      int bn, lat, gap;
      logic [7:0] ra, rb;
      out_ready = 1'b0;
      run_op(8'hC3, 8'h17, bn, lat);
      a = 8'h12;
      b = 8'h34;
      start = 1'b1;
      out_ready = 1'b1;
      tick();
      start = 1'b0;
      checks++;
      if (busy !== 1'b1 || out_valid !== 1'b0) begin
         errors++;
         $display("FAIL b2b_direct_run got busy %b valid %b want 1 0", busy, out_valid);
      end
      lat = 1;
      while (!out_valid && lat < 30) begin tick(); lat++; end
      checks++;
      if (product !== 16'h03A8 || lat !== 9) begin
         errors++;
         $display("FAIL b2b_product got %h lat %0d want 03a8 lat 9", product, lat);
      end
      // Streaming: start held high, out_ready high, new operands per result.
      for (int i = 0; i < 3; i++) begin
         ra = 8'($urandom);
         rb = 8'($urandom);
         a = ra;
         b = rb;
         start = 1'b1;
         tick();
         gap = 1;
         while (!out_valid && gap < 30) begin tick(); gap++; end
         checks++;
         if (gap !== 9 || product !== ref_mul(ra, rb)) begin
            errors++;
            $display("FAIL stream_op %h*%h got %h gap %0d want %h gap 9", ra, rb, product, gap, ref_mul(ra, rb));
         end
      end
      start = 1'b0;
      tick();
   endtask

   task automatic test_reset_mid_run();
      int bn, lat, seen;
      out_ready = 1'b1;
      a = 8'hE7;
      b = 8'hB9;
      start = 1'b1;
      tick();
      start = 1'b0;
      tick();
      tick();
      tick();
      #2;
      rst = 1'b1;
      #1;
      checks++;
      if (busy !== 1'b0 || out_valid !== 1'b0 || product !== 16'h0) begin
         errors++;
         $display("FAIL midrun_async_clear got busy %b valid %b product %h want 0 0 0000", busy, out_valid, product);
      end
      tick();
      rst = 1'b0;
      seen = 0;
      for (int i = 0; i < 15; i++) begin
         tick();
         if (out_valid || busy) seen++;
      end
      checks++;
      if (seen !== 0) begin errors++; $display("FAIL midrun_no_stale got %0d active cycles want 0", seen); end
      run_op(8'h07, 8'h06, bn, lat);
      checks++;
      if (product !== 16'h002A || lat !== 9) begin
         errors++;
         $display("FAIL midrun_fresh got %h lat %0d want 002a lat 9", product, lat);
      end
      tick();
   endtask

   initial begin
      test_reset();
      test_basic();
      test_corners();
      test_random();
      test_backpressure();
      test_back_to_back();
      test_reset_mid_run();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule : tb_mul8_shift_add
